// File: rtl/hazard_scoreboard.sv
// Load-use / forwarding hazard unit for the 5-stage MIPS pipeline.
// Shift-register scoreboard of in-flight writes, one entry per stage.
module hazard_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 32,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wen,
    input  logic [ADDR_W-1:0] id_waddr,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic              id_flush,
    input  logic              mem_busy,
    output logic              stall,
    output logic              bubble,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic              fwd_m,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [FWD_STAGES:1] ent_v;
    logic [ADDR_W-1:0]   ent_wa  [1:FWD_STAGES];
    logic [SEL_W-1:0]    ent_rdy [1:FWD_STAGES];

    logic             a_hit, b_hit;
    logic [SEL_W-1:0] a_k, b_k, a_rdy, b_rdy;
    logic             a_haz, b_raw_haz, b_late, b_haz;
    logic             hazard, issue;

    // Find the youngest matching entry per operand; scan oldest first so
    // later (younger) hits overwrite.
    always_comb begin
        a_hit = 1'b0;
        a_k   = '0;
        a_rdy = '0;
        b_hit = 1'b0;
        b_k   = '0;
        b_rdy = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (ent_v[k] && ent_wa[k] == id_rs &&
                id_rs != '0 && id_rs_used) begin
                a_hit = 1'b1;
                a_k   = SEL_W'(k);
                a_rdy = ent_rdy[k];
            end
            if (ent_v[k] && ent_wa[k] == id_rt &&
                id_rt != '0 && id_rt_used) begin
                b_hit = 1'b1;
                b_k   = SEL_W'(k);
                b_rdy = ent_rdy[k];
            end
        end
    end

    // Forward selects and hazard; store data one stage short of ready
    // is picked up late from MEM instead of stalling.
    always_comb begin
        a_haz     = a_hit && (a_k < a_rdy);
        b_raw_haz = b_hit && (b_k < b_rdy);
        b_late    = id_is_store && b_raw_haz &&
                    ({1'b0, b_rdy} == ({1'b0, b_k} + (SEL_W+1)'(1)));
        b_haz     = b_raw_haz && !b_late;
        fwd_a_sel = (a_hit && !a_haz) ? a_k : '0;
        fwd_b_sel = (b_hit && !b_raw_haz) ? b_k : '0;
        fwd_m     = b_late;
        hazard    = id_valid && (a_haz || b_haz);
        stall     = hazard || mem_busy;
        bubble    = hazard && !mem_busy && !id_flush;
        issue     = id_valid && !hazard && !id_flush;
    end

    // Scoreboard shift: insert issued writer, age the rest; freeze on mem_busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_v <= '0;
            for (int k = 1; k <= FWD_STAGES; k++) begin
                ent_wa[k]  <= '0;
                ent_rdy[k] <= '0;
            end
        end else if (!mem_busy) begin
            ent_v[1]   <= issue && id_wen && (id_waddr != '0);
            ent_wa[1]  <= issue ? id_waddr : '0;
            ent_rdy[1] <= !issue ? '0 :
                          id_is_load ? SEL_W'(LOAD_STAGE) : SEL_W'(1);
            for (int k = 2; k <= FWD_STAGES; k++) begin
                ent_v[k]   <= ent_v[k-1];
                ent_wa[k]  <= ent_wa[k-1];
                ent_rdy[k] <= ent_rdy[k-1];
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Expected responses queued by stimulus, checked by a negedge monitor.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs_used, id_rt_used, id_wen;
    logic        id_is_load, id_is_store, id_flush, mem_busy;
    logic [4:0]  id_rs, id_rt, id_waddr;
    logic        stall, bubble, fwd_m;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt;

    typedef struct {
        string       name;
        logic        stall;
        logic        bubble;
        logic [1:0]  a;
        logic [1:0]  b;
        logic        m;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wen(id_wen), .id_waddr(id_waddr),
        .id_is_load(id_is_load), .id_is_store(id_is_store),
        .id_flush(id_flush), .mem_busy(mem_busy),
        .stall(stall), .bubble(bubble),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fwd_m(fwd_m), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are combinational, so compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            compared++;
            if (stall !== e.stall || bubble !== e.bubble ||
                fwd_a_sel !== e.a || fwd_b_sel !== e.b ||
                fwd_m !== e.m || stall_cnt !== e.cnt) begin
                mismatched++;
                $display("FAIL %s: got stall=%b bubble=%b a=%0d b=%0d m=%b cnt=%0d, want stall=%b bubble=%b a=%0d b=%0d m=%b cnt=%0d",
                         e.name, stall, bubble, fwd_a_sel, fwd_b_sel,
                         fwd_m, stall_cnt, e.stall, e.bubble, e.a, e.b,
                         e.m, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic v, input logic [4:0] rs,
                      input logic [4:0] rt, input logic ru,
                      input logic tu, input logic wen,
                      input logic [4:0] wa, input logic ld,
                      input logic st);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_rs_used  = ru;
        id_rt_used  = tu;
        id_wen      = wen;
        id_waddr    = wa;
        id_is_load  = ld;
        id_is_store = st;
    endtask

    task automatic expect_out(input string n, input logic s,
                              input logic bb, input logic [1:0] a,
                              input logic [1:0] b, input logic m,
                              input logic [31:0] c);
        exp_t e;
        e.name = n; e.stall = s; e.bubble = bb;
        e.a = a; e.b = b; e.m = m; e.cnt = c;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b0;
        id_flush = 1'b0;
        mem_busy = 1'b0;
        id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;

        // add $3,$1,$2 then add $4,$3,$3
        id(1, 1, 2, 1, 1, 1, 3, 0, 0);
        expect_out("alu1", 0, 0, 0, 0, 0, 0);
        tick();
        id(1, 3, 3, 1, 1, 1, 4, 0, 0);
        expect_out("alu_b2b", 0, 0, 1, 1, 0, 0);
        tick();

        // lw $5 then add $6,$5,$1
        id(1, 1, 0, 1, 0, 1, 5, 1, 0);
        expect_out("lw5", 0, 0, 0, 0, 0, 0);
        tick();
        id(1, 5, 1, 1, 1, 1, 6, 0, 0);
        expect_out("loaduse_c1", 1, 1, 0, 0, 0, 0);
        tick();
        expect_out("loaduse_c2", 0, 0, 2, 0, 0, 1);
        tick();

        // lw $5; sw $5,0($2)
        id(1, 2, 0, 1, 0, 1, 5, 1, 0);
        expect_out("lw5_again", 0, 0, 0, 0, 0, 1);
        tick();
        id(1, 2, 5, 1, 1, 0, 0, 0, 1);
        expect_out("store_late", 0, 0, 0, 0, 1, 1);
        tick();

        // add $7; add $7; add $8,$7,$0
        id(1, 1, 1, 1, 1, 1, 7, 0, 0);
        expect_out("add7_a", 0, 0, 0, 0, 0, 1);
        tick();
        expect_out("add7_b", 0, 0, 0, 0, 0, 1);
        tick();
        id(1, 7, 0, 1, 1, 1, 8, 0, 0);
        expect_out("youngest", 0, 0, 1, 0, 0, 1);
        tick();

        // $0 writer then $0 reader
        id(1, 1, 1, 1, 1, 1, 0, 0, 0);
        expect_out("w0", 0, 0, 0, 0, 0, 1);
        tick();
        id(1, 0, 0, 1, 1, 1, 9, 0, 0);
        expect_out("r0", 0, 0, 0, 0, 0, 1);
        tick();

        // lw $10; add $11,$10,$10 under a 3-cycle memory freeze
        id(1, 1, 0, 1, 0, 1, 10, 1, 0);
        expect_out("lw10", 0, 0, 0, 0, 0, 1);
        tick();
        id(1, 10, 10, 1, 1, 1, 11, 0, 0);
        mem_busy = 1'b1;
        expect_out("busy1", 1, 0, 0, 0, 0, 1);
        tick();
        expect_out("busy2", 1, 0, 0, 0, 0, 2);
        tick();
        expect_out("busy3", 1, 0, 0, 0, 0, 3);
        tick();
        mem_busy = 1'b0;
        expect_out("busy_done", 1, 1, 0, 0, 0, 4);
        tick();
        expect_out("busy_fwd", 0, 0, 2, 2, 0, 5);
        tick();

        // lw $12; flushed add $13,$12,$1; then read $13,$12
        id(1, 1, 0, 1, 0, 1, 12, 1, 0);
        expect_out("lw12", 0, 0, 0, 0, 0, 5);
        tick();
        id(1, 12, 1, 1, 1, 1, 13, 0, 0);
        id_flush = 1'b1;
        expect_out("flush_haz", 1, 0, 0, 0, 0, 5);
        tick();
        id_flush = 1'b0;
        id(1, 13, 12, 1, 1, 1, 14, 0, 0);
        expect_out("flush_noins", 0, 0, 0, 2, 0, 6);
        tick();
        id(1, 14, 12, 1, 1, 0, 0, 0, 0);
        expect_out("split_stg", 0, 0, 1, 3, 0, 6);
        tick();

        // lw $15; use stalled by freeze; reset mid-stall
        id(1, 1, 0, 1, 0, 1, 15, 1, 0);
        expect_out("lw15", 0, 0, 0, 0, 0, 6);
        tick();
        id(1, 15, 0, 1, 0, 1, 16, 0, 0);
        mem_busy = 1'b1;
        expect_out("pre_rst", 1, 0, 0, 0, 0, 6);
        tick();
        rst = 1'b0;
        expect_out("rst_busy", 1, 0, 0, 0, 0, 0);
        tick();
        mem_busy = 1'b0;
        expect_out("rst_idle", 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        expect_out("post_rst", 0, 0, 0, 0, 0, 0);
        tick();
        id(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d checks left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit hit, want finish");
        $fatal(1);
    end

endmodule
